// File: rtl/mppc_pkg.sv
// Shared definitions for the MPPC coincidence counter.
//   FRAME_HDR : first byte of every count frame
//   state_e   : frame transmitter state
//   frame_len : total frame length in bytes (header + every count, MSB byte first)
package mppc_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_e;

  function automatic int frame_len(input int n_ch, input int cnt_w);
    return 1 + ((n_ch + 1) * cnt_w) / 8;
  endfunction

endpackage

// File: rtl/mppc_hit_window.sv
// One MPPC channel front end: 2-flop synchroniser, rising-edge detector and
// coincidence window counter.
// Ports:
//   CLK, RST : system clock, asynchronous active-high reset
//   ch_in    : raw discriminator input, asynchronous to CLK
//   hit      : one-cycle pulse, 3 cycles after a rising edge on ch_in
//   active   : hit, or the window started by the last hit has not yet expired
module mppc_hit_window #(
  parameter int WINDOW = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic ch_in,
  output logic hit,
  output logic active
);

  localparam int WIN_W = $clog2(WINDOW + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic             hit_q, hit_d;
  logic [WIN_W-1:0] win_q, win_d;

  always_comb begin
    sync1_d = ch_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    // Registered edge so the hit is aligned 3 cycles after the raw edge.
    hit_d   = sync2_q & ~prev_q;
    // A new hit always reloads the window, even while it is still running.
    if (hit_q) begin
      win_d = WIN_W'(WINDOW);
    end else if (win_q != '0) begin
      win_d = win_q - WIN_W'(1);
    end else begin
      win_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      hit_q   <= 1'b0;
      win_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      hit_q   <= hit_d;
      win_q   <= win_d;
    end
  end

  assign hit    = hit_q;
  assign active = hit_q | (win_q != '0);

endmodule

// File: rtl/coincidence_counter.sv
// N-channel MPPC singles and coincidence counter with per-gate frame output.
// Counts singles per channel plus one N-fold coincidence over a fixed gate,
// snapshots all counts at each gate end and streams them as a byte frame:
// A5, ch0 .. ch(N_CH-1), coincidence, each count MSB byte first.
// Ports:
//   CLK, RST    : system clock, asynchronous active-high reset
//   enable      : high = counting; low holds live counters and gate timer at 0
//   ch_in       : raw discriminator inputs (asynchronous)
//   coinc_mask  : channels required for the coincidence (0 = never)
//   coinc_pulse : one-cycle pulse per new coincidence
//   tx_data     : frame byte
//   tx_valid    : tx_data valid
//   tx_ready    : consumer ready
//   overrun     : sticky, a gate ended while a frame was still being sent
//   dbg_state   : current transmitter state (state_e encoding)
module coincidence_counter
  import mppc_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 4,
  parameter int GATE_CYCLES = 9600000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            enable,
  input  logic [N_CH-1:0] ch_in,
  input  logic [N_CH-1:0] coinc_mask,
  output logic            coinc_pulse,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            overrun,
  output logic [1:0]      dbg_state
);

  localparam int N_CNT      = N_CH + 1;
  localparam int FRAME_LEN  = frame_len(N_CH, CNT_W);
  localparam int DATA_BYTES = FRAME_LEN - 1;
  localparam int DATA_BITS  = N_CNT * CNT_W;
  localparam int IDX_W      = $clog2(DATA_BYTES);
  localparam int GATE_W     = $clog2(GATE_CYCLES + 1);

  // ---------------- channel front ends ----------------
  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] active;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    mppc_hit_window #(.WINDOW(WINDOW)) u_hw (
      .CLK    (CLK),
      .RST    (RST),
      .ch_in  (ch_in[g]),
      .hit    (hit[g]),
      .active (active[g])
    );
  end

  // ---------------- coincidence ----------------
  logic cond;
  logic cond_q, cond_d;
  logic pulse_q, pulse_d;

  always_comb begin
    cond    = (coinc_mask != '0) && (&(active | ~coinc_mask));
    cond_d  = cond;
    // Rising edge of cond: one count per overlap, however long it lasts.
    pulse_d = cond & ~cond_q;
  end

  // ---------------- gate timer and live counters ----------------
  logic [GATE_W-1:0] gate_q, gate_d;
  logic              terminal;
  logic [N_CNT-1:0]  inc;
  logic [CNT_W-1:0]  cnt_q [N_CNT];
  logic [CNT_W-1:0]  cnt_d [N_CNT];

  always_comb begin
    inc      = {pulse_d, hit};
    terminal = enable && (gate_q == GATE_W'(GATE_CYCLES - 1));
    if (!enable || terminal) begin
      gate_d = '0;
    end else begin
      gate_d = gate_q + GATE_W'(1);
    end
    for (int i = 0; i < N_CNT; i++) begin
      if (!enable) begin
        cnt_d[i] = '0;
      end else if (terminal) begin
        // The old value goes to the snapshot; this cycle's event opens the next gate.
        cnt_d[i] = {{(CNT_W-1){1'b0}}, inc[i]};
      end else if (cnt_q[i] == '1) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, inc[i]};
      end
    end
  end

  // Live counts packed in frame order, ch0 at the top so bytes shift out MSB first.
  logic [DATA_BITS-1:0] snap_pack;

  always_comb begin
    snap_pack = '0;
    for (int i = 0; i < N_CNT; i++) begin
      snap_pack[(N_CNT-1-i)*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  // ---------------- frame transmitter ----------------
  // Handshake: a byte transfers on a rising CLK edge with tx_valid && tx_ready.
  // tx_valid and tx_data are registered; while tx_valid && !tx_ready both stay
  // unchanged. After each accept tx_valid drops for one cycle and the next byte
  // is presented on the following cycle (at most 1 byte per 2 cycles).
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] snap_q, snap_d;
  logic                 valid_q, valid_d;
  logic [7:0]           data_q, data_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    valid_d   = valid_q;
    data_d    = data_q;
    // A gate end mid-frame drops the new snapshot; the current frame goes out unaltered.
    overrun_d = overrun_q | (terminal && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (terminal) begin
          snap_d  = snap_pack;
          state_d = HEADER;
          valid_d = 1'b1;
          data_d  = FRAME_HDR;
        end
      end
      HEADER: begin
        if (valid_q && tx_ready) begin
          valid_d = 1'b0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (valid_q) begin
          if (tx_ready) begin
            valid_d = 1'b0;
            snap_d  = snap_q << 8;
            if (idx_q == IDX_W'(DATA_BYTES - 1)) begin
              state_d = IDLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end else begin
          valid_d = 1'b1;
          data_d  = snap_q[DATA_BITS-1 -: 8];
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cond_q    <= 1'b0;
      pulse_q   <= 1'b0;
      gate_q    <= '0;
      for (int i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      cond_q    <= cond_d;
      pulse_q   <= pulse_d;
      gate_q    <= gate_d;
      for (int i = 0; i < N_CNT; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign coinc_pulse = pulse_q;
  assign tx_data     = data_q;
  assign tx_valid    = valid_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_coincidence_counter.sv
// Directed bench for coincidence_counter: a main instance (4 ch, 16-bit counts,
// 200-cycle gate) and a saturation instance (4 ch, 8-bit counts, 2000-cycle gate).
module tb_coincidence_counter;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       enable = 1'b0;
  logic [3:0] ch_in = 4'b0;
  logic [3:0] coinc_mask = 4'b0;
  logic       coinc_pulse;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       overrun;
  logic [1:0] dbg_state;

  logic       enable2 = 1'b0;
  logic [3:0] ch_in2 = 4'b0;
  logic [3:0] coinc_mask2 = 4'b0;
  logic       coinc_pulse2;
  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2 = 1'b1;
  logic       overrun2;
  logic [1:0] dbg_state2;

  coincidence_counter #(.N_CH(4), .CNT_W(16), .WINDOW(4), .GATE_CYCLES(200)) u_dut (
    .CLK(clk), .RST(rst), .enable(enable), .ch_in(ch_in), .coinc_mask(coinc_mask),
    .coinc_pulse(coinc_pulse), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .overrun(overrun), .dbg_state(dbg_state)
  );

  coincidence_counter #(.N_CH(4), .CNT_W(8), .WINDOW(4), .GATE_CYCLES(2000)) u_sat (
    .CLK(clk), .RST(rst), .enable(enable2), .ch_in(ch_in2), .coinc_mask(coinc_mask2),
    .coinc_pulse(coinc_pulse2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .overrun(overrun2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got2_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         coinc_seen = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Byte collection, coincidence pulse count and stall stability, sampled on negedge.
  always @(negedge clk) begin
    if (rst) begin
      got_q.delete();
      got2_q.delete();
      coinc_seen <= 0;
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, stall_data);
      end
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (tx_valid2 && tx_ready2) got2_q.push_back(tx_data2);
      if (coinc_pulse) coinc_seen <= coinc_seen + 1;
      stall_prev <= tx_valid && !tx_ready;
      stall_data <= tx_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      cyc++;
    end
  endtask

  task automatic do_reset(input bit en_main, input bit en_sat);
    rst = 1'b1;
    enable = 1'b0;
    enable2 = 1'b0;
    ch_in = 4'b0;
    ch_in2 = 4'b0;
    tick(2);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_coinc_pulse", coinc_pulse, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, 0);
    check("rst_sat_valid", tx_valid2, 0);
    exp_q.delete();
    rst = 1'b0;
    // Cycle 0 of the first gate is the current cycle.
    enable = en_main;
    enable2 = en_sat;
    cyc = 0;
  endtask

  task automatic pulse(input logic [3:0] m, input int n, input bit sat);
    repeat (n) begin
      if (sat) ch_in2 = ch_in2 | m; else ch_in = ch_in | m;
      tick(2);
      if (sat) ch_in2 = ch_in2 & ~m; else ch_in = ch_in & ~m;
      tick(2);
    end
  endtask

  task automatic push_frame(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3, input logic [15:0] wc);
    logic [15:0] w [5];
    w = '{w0, w1, w2, w3, wc};
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(w[i][15:8]);
      exp_q.push_back(w[i][7:0]);
    end
  endtask

  task automatic wait_compare(input string tag, input int limit, input bit sat);
    int t;
    int n;
    logic [7:0] e;
    logic [31:0] g;
    t = 0;
    n = exp_q.size();
    while (((sat ? got2_q.size() : got_q.size()) < n) && (t < limit)) begin
      tick(1);
      t++;
    end
    check({tag, "_bytes_arrived"}, ((sat ? got2_q.size() : got_q.size()) >= n), 1);
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      if (sat) g = (got2_q.size() > 0) ? {24'h0, got2_q.pop_front()} : 32'hFFFF_FFFF;
      else     g = (got_q.size() > 0)  ? {24'h0, got_q.pop_front()}  : 32'hFFFF_FFFF;
      check($sformatf("%s_b%0d", tag, k), g, {24'h0, e});
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int t;

    // 1: singles, simultaneous hits on ch0/ch2, mask=0 never coincides
    do_reset(1, 0);
    pulse(4'b0101, 3, 0);
    pulse(4'b0100, 2, 0);
    push_frame(16'd3, 16'd0, 16'd5, 16'd0, 16'd0);
    wait_compare("singles", 300, 0);
    check("mask0_no_coinc", coinc_seen, 0);

    // 2: coincidence with 2-cycle gap, then no coincidence with 6-cycle gap
    do_reset(1, 0);
    coinc_mask = 4'b0011;
    tick(3);
    ch_in = 4'b0001; tick(2);
    ch_in = 4'b0010; tick(2);
    ch_in = 4'b0000; tick(20);
    check("coinc_gap2", coinc_seen, 1);
    ch_in = 4'b0001; tick(2);
    ch_in = 4'b0000; tick(4);
    ch_in = 4'b0010; tick(2);
    ch_in = 4'b0000; tick(20);
    check("coinc_gap6", coinc_seen, 1);
    push_frame(16'd2, 16'd2, 16'd0, 16'd0, 16'd1);
    wait_compare("coinc", 300, 0);
    coinc_mask = 4'b0000;

    // 4: backpressure across two gate ends
    do_reset(1, 0);
    tx_ready = 1'b0;
    pulse(4'b0010, 2, 0);
    pulse(4'b1000, 1, 0);
    while (cyc < 250) tick(1);
    pulse(4'b0001, 4, 0);
    while (cyc < 405) tick(1);
    check("bp_overrun", overrun, 1);
    check("bp_valid_held", tx_valid, 1);
    check("bp_hdr_held", tx_data, 8'hA5);
    check("bp_nothing_sent", got_q.size(), 0);
    tx_ready = 1'b1;
    push_frame(16'd0, 16'd2, 16'd0, 16'd1, 16'd0);
    wait_compare("bp_first", 100, 0);
    push_frame(16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    wait_compare("bp_next", 300, 0);
    check("bp_overrun_sticky", overrun, 1);

    // 5: hit on the terminal gate cycle goes to the next gate
    do_reset(1, 0);
    while (cyc < 196) tick(1);
    ch_in = 4'b0010; tick(2);
    ch_in = 4'b0000;
    push_frame(16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    push_frame(16'd0, 16'd1, 16'd0, 16'd0, 16'd0);
    wait_compare("boundary", 300, 0);

    // 6: reset during byte 4
    do_reset(1, 0);
    pulse(4'b0100, 2, 0);
    t = 0;
    while (!(got_q.size() == 4 && tx_valid) && (t < 300)) begin
      tick(1);
      t++;
    end
    check("midrst_reach_byte4", got_q.size(), 4);
    rst = 1'b1;
    #1;
    check("midrst_valid_low", tx_valid, 0);
    check("midrst_overrun", overrun, 0);
    do_reset(1, 0);
    pulse(4'b1000, 1, 0);
    push_frame(16'd0, 16'd0, 16'd0, 16'd1, 16'd0);
    wait_compare("after_rst", 300, 0);

    // 3: saturation on the 8-bit instance
    do_reset(0, 1);
    pulse(4'b0001, 2, 1);
    pulse(4'b1000, 300, 1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    wait_compare("sat", 2300, 1);
    check("sat_overrun", overrun2, 0);
    check("sat_no_coinc", coinc_pulse2, 0);
    check("sat_state_idle", dbg_state2, 0);
    check("sat_main_disabled", got_q.size(), 0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
